cp0_exc_unit: RTL

- Coprocessor-0 register file and precise-exception unit for the 5-stage MIPS core.
- Sits downstream of instruction decode. Consumes the decoder's SYSC_EXP/BREAK_EXP/RI_EXP/MFCP0/MTCP0 flags once they are pipelined to the commit (MEM) stage, together with overflow and address-error flags.
- Holds BadVAddr/Count/Compare/Status/Cause/EPC and resolves exception priority.
- Drives the pipeline flush and the redirect PC for exceptions and ERET.

---
 rtl/cp0_defs.sv | 24 ++
 rtl/cp0_exc_prio.sv | 28 ++
 rtl/cp0_exc_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/cp0_defs.sv
// cp0_defs: CP0 register addresses, exception codes, bit positions and reset/vector defaults.
package cp0_defs;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam int ST_IE   = 0;
  localparam int ST_EXL  = 1;
  localparam int CA_BD   = 31;
  localparam int CA_TI   = 30;
  localparam logic [31:0] STATUS_WMASK   = 32'h0000_ff03;
  localparam logic [31:0] CAUSE_WMASK    = 32'h0000_0300;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hbfc0_0380;
  localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0000;
endpackage

// File: rtl/cp0_exc_prio.sv
// cp0_exc_prio: fixed-priority exception encoder; inputs are already qualified by a valid commit.
module cp0_exc_prio
  import cp0_defs::*;
(
  input  logic       int_pend_i,
  input  logic       adel_if_i,
  input  logic       ri_i,
  input  logic       ov_i,
  input  logic       sys_i,
  input  logic       bp_i,
  input  logic       adel_ld_i,
  input  logic       ades_i,
  output logic       exc_take_o,
  output logic [4:0] exc_code_o,
  output logic       is_badaddr_fetch_o,
  output logic       is_badaddr_data_o
);
  assign exc_take_o = |{int_pend_i, adel_if_i, ri_i, ov_i, sys_i, bp_i, adel_ld_i, ades_i};
  assign exc_code_o = int_pend_i ? EXC_INT  :
                      adel_if_i  ? EXC_ADEL :
                      ri_i       ? EXC_RI   :
                      ov_i       ? EXC_OV   :
                      sys_i      ? EXC_SYS  :
                      bp_i       ? EXC_BP   :
                      adel_ld_i  ? EXC_ADEL : EXC_ADES;
  assign is_badaddr_fetch_o = ~int_pend_i & adel_if_i;
  assign is_badaddr_data_o  = ~|{int_pend_i, adel_if_i, ri_i, ov_i, sys_i, bp_i} & (adel_ld_i | ades_i);
endmodule

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: CP0 register file and precise-exception/ERET redirect for the commit stage.
// Optional timer interrupt (Count==Compare -> Cause.TI, IP7) enabled by defining CP0_TIMER_INT_EN.
module cp0_exc_unit
  import cp0_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic        sysc_exp,
  input  logic        break_exp,
  input  logic        ri_exp,
  input  logic        ov_exp,
  input  logic        adel_if,
  input  logic        adel_ld,
  input  logic        ades,
  input  logic [31:0] bad_addr,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] mtc0_wdata,
  output logic [31:0] mfc0_rdata,
  input  logic [5:0]  ext_int,
  output logic        exc_flush,
  output logic [31:0] exc_target,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);
  logic [31:0] badvaddr_q, badvaddr_d, count_q, count_d, compare_q, compare_d;
  logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d;
  logic        tick_q;
  logic        exc_take, exc_fetch, exc_data, eret_take, int_pend, wr;
  logic [4:0]  exc_code;
`ifdef CP0_TIMER_INT_EN
  logic        cmp_wr_q, cmp_wr_d;
`endif
  assign int_pend = status_q[ST_IE] & ~status_q[ST_EXL] & |(cause_q[15:8] & status_q[15:8]);
  cp0_exc_prio u_prio (
    .int_pend_i         (mem_valid & int_pend),
    .adel_if_i          (mem_valid & adel_if),
    .ri_i               (mem_valid & ri_exp),
    .ov_i               (mem_valid & ov_exp),
    .sys_i              (mem_valid & sysc_exp),
    .bp_i               (mem_valid & break_exp),
    .adel_ld_i          (mem_valid & adel_ld),
    .ades_i             (mem_valid & ades),
    .exc_take_o         (exc_take),
    .exc_code_o         (exc_code),
    .is_badaddr_fetch_o (exc_fetch),
    .is_badaddr_data_o  (exc_data)
  );
  // an excepting commit never retires its MTC0
  assign wr         = mtc0_we & ~exc_take;
  assign eret_take  = mem_valid & eret & ~exc_take;
  assign exc_flush  = exc_take | eret_take;
  assign exc_target = exc_take ? EXC_VECTOR : epc_q;
  assign status_o   = status_q;
  assign cause_o    = cause_q;
  assign epc_o      = epc_q;
  assign mfc0_rdata = cp0_addr == CP0_BADVADDR ? badvaddr_q :
                      cp0_addr == CP0_COUNT    ? count_q    :
                      cp0_addr == CP0_COMPARE  ? compare_q  :
                      cp0_addr == CP0_STATUS   ? status_q   :
                      cp0_addr == CP0_CAUSE    ? cause_q    :
                      cp0_addr == CP0_EPC      ? epc_q      : 32'd0;
  always_comb begin
    count_d   = (wr && cp0_addr == CP0_COUNT) ? mtc0_wdata : count_q + {31'd0, tick_q};
    compare_d = (wr && cp0_addr == CP0_COMPARE) ? mtc0_wdata : compare_q;
    epc_d     = (wr && cp0_addr == CP0_EPC) ? mtc0_wdata : epc_q;
    status_d  = (wr && cp0_addr == CP0_STATUS) ? (status_q & ~STATUS_WMASK) | (mtc0_wdata & STATUS_WMASK) : status_q;
    cause_d   = (wr && cp0_addr == CP0_CAUSE) ? (cause_q & ~CAUSE_WMASK) | (mtc0_wdata & CAUSE_WMASK) : cause_q;
    badvaddr_d = badvaddr_q;
`ifdef CP0_TIMER_INT_EN
    cmp_wr_d = cmp_wr_q | (wr && cp0_addr == CP0_COMPARE);
    cause_d[CA_TI] = (wr && cp0_addr == CP0_COMPARE) ? 1'b0 :
                     (count_q == compare_q && (compare_q != 32'd0 || cmp_wr_q)) ? 1'b1 : cause_q[CA_TI];
`else
    cause_d[CA_TI] = 1'b0;
`endif
    cause_d[15:10] = {ext_int[5] | cause_q[CA_TI], ext_int[4:0]};
    if (exc_take) begin
      cause_d[6:2] = exc_code;
      status_d[ST_EXL] = 1'b1;
      if (!status_q[ST_EXL]) begin
        epc_d = mem_bd ? mem_pc - 32'd4 : mem_pc;
        cause_d[CA_BD] = mem_bd;
      end
      badvaddr_d = exc_fetch ? mem_pc : exc_data ? bad_addr : badvaddr_q;
    end
    if (eret_take) status_d[ST_EXL] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_q   <= STATUS_RST;
      cause_q    <= '0;
      epc_q      <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      badvaddr_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      badvaddr_q <= badvaddr_d;
      tick_q     <= ~tick_q;
    end
  end
`ifdef CP0_TIMER_INT_EN
  always_ff @(posedge clk) cmp_wr_q <= resetn ? cmp_wr_d : 1'b0;
`endif
endmodule
